// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit: req/ack data-memory bus master with stall and fault handling
// Formats store data, extends load data, and stalls the pipeline until the bus access completes or times out.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic [31:0] ALU_OUT_MEM,
  input  logic [31:0] STORE_DATA_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] DATA_MEMORY_MEM,
  output logic        mem_stall,
  output logic        access_fault,
  output logic        bus_error
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic        berr_q, berr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;

  logic        access;
  logic        legal;
  logic        misaligned;
  logic        fault;
  logic        issue;
  logic        timeout_hit;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] rdata_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign access      = MemRead_MEM | MemWrite_MEM;
  assign fault       = access & (~legal | misaligned | (MemRead_MEM & MemWrite_MEM));
  assign issue       = access & ~fault;
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  // Request decode: legality, alignment and lane formatting of the IDLE-cycle inputs
  always_comb begin
    legal = 1'b0;
    if (MemRead_MEM) begin
      legal = (funct3_MEM == 3'b000) | (funct3_MEM == 3'b001) | (funct3_MEM == 3'b010) |
              (funct3_MEM == 3'b100) | (funct3_MEM == 3'b101);
    end else begin
      legal = (funct3_MEM == 3'b000) | (funct3_MEM == 3'b001) | (funct3_MEM == 3'b010);
    end

    misaligned = 1'b0;
    case (funct3_MEM[1:0])
      2'b01:   misaligned = ALU_OUT_MEM[0];
      2'b10:   misaligned = (ALU_OUT_MEM[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase

    be_fmt    = 4'b1111;
    wdata_fmt = 32'h0;
    case (funct3_MEM[1:0])
      2'b00: begin
        be_fmt    = 4'b0001 << ALU_OUT_MEM[1:0];
        wdata_fmt = {4{STORE_DATA_MEM[7:0]}};
      end
      2'b01: begin
        be_fmt    = ALU_OUT_MEM[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{STORE_DATA_MEM[15:0]}};
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = STORE_DATA_MEM;
      end
    endcase
    if (!MemWrite_MEM) begin
      wdata_fmt = 32'h0;
    end
  end

  // Load extension uses the lane and funct3 captured at issue, not the live inputs
  always_comb begin
    rdata_shift = dmem_rdata >> {lane_q, 3'b000};
    byte_sel    = rdata_shift[7:0];
    half_sel    = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue) state_d = S_WAIT;
      S_WAIT:  if (dmem_ack || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_stall    = 1'b0;
    access_fault = 1'b0;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    data_d       = data_q;
    berr_d       = 1'b0;
    cnt_d        = cnt_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    case (state_q)
      S_IDLE: begin
        mem_stall    = issue;
        access_fault = fault;
        if (issue) begin
          req_d    = 1'b1;
          we_d     = MemWrite_MEM;
          addr_d   = {ALU_OUT_MEM[31:2], 2'b00};
          be_d     = be_fmt;
          wdata_d  = wdata_fmt;
          cnt_d    = 8'h0;
          funct3_d = funct3_MEM;
          lane_d   = ALU_OUT_MEM[1:0];
        end
      end
      S_WAIT: begin
        mem_stall = 1'b1;
        // An ack in the same cycle as the timeout takes priority
        if (dmem_ack) begin
          req_d = 1'b0;
          if (!we_q) begin
            data_d = load_ext;
          end
        end else if (timeout_hit) begin
          req_d  = 1'b0;
          berr_d = 1'b1;
          data_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      default: begin
        mem_stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      data_q   <= 32'h0;
      berr_q   <= 1'b0;
      cnt_q    <= 8'h0;
      funct3_q <= 3'h0;
      lane_q   <= 2'h0;
    end else begin
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      berr_q   <= berr_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      lane_q   <= lane_d;
    end
  end

  assign dmem_req        = req_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_be         = be_q;
  assign dmem_wdata      = wdata_q;
  assign DATA_MEMORY_MEM = data_q;
  assign bus_error       = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
// Inputs driven and outputs sampled on the falling clock edge; DUT built with TIMEOUT=4.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        MemRead_MEM;
  logic        MemWrite_MEM;
  logic [2:0]  funct3_MEM;
  logic [31:0] ALU_OUT_MEM;
  logic [31:0] STORE_DATA_MEM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] DATA_MEMORY_MEM;
  logic        mem_stall;
  logic        access_fault;
  logic        bus_error;

  int checks;
  int failures;

  logic        o_stall_idle, o_fault, o_req, o_we;
  logic [31:0] o_addr, o_wdata, o_data;
  logic [3:0]  o_be;
  int          o_waits;
  logic        o_done_stall, o_done_req, o_berr;
  logic        o_after_stall, o_after_berr, o_after_req;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .MemRead_MEM    (MemRead_MEM),
    .MemWrite_MEM   (MemWrite_MEM),
    .funct3_MEM     (funct3_MEM),
    .ALU_OUT_MEM    (ALU_OUT_MEM),
    .STORE_DATA_MEM (STORE_DATA_MEM),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack),
    .DATA_MEMORY_MEM(DATA_MEMORY_MEM),
    .mem_stall      (mem_stall),
    .access_fault   (access_fault),
    .bus_error      (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One MEM-stage instruction; ack_at = WAIT-cycle index of the ack, -1 for none
  task automatic run(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input int ack_at, input logic [31:0] rdv);
    int w;
    @(negedge clk);
    MemRead_MEM = rd; MemWrite_MEM = wr; funct3_MEM = f3;
    ALU_OUT_MEM = a; STORE_DATA_MEM = sd; dmem_ack = 1'b0;
    #1;
    o_stall_idle = mem_stall;
    o_fault      = access_fault;
    w = 0;
    @(negedge clk);
    o_req = dmem_req; o_we = dmem_we; o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata;
    while (mem_stall && w < 40) begin
      if (w == ack_at) begin
        dmem_ack = 1'b1; dmem_rdata = rdv;
      end else begin
        dmem_ack = 1'b0;
      end
      w++;
      @(negedge clk);
    end
    dmem_ack     = 1'b0;
    o_waits      = w;
    o_done_stall = mem_stall;
    o_done_req   = dmem_req;
    o_data       = DATA_MEMORY_MEM;
    o_berr       = bus_error;
    @(negedge clk);
    MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0;
    #1;
    o_after_stall = mem_stall;
    o_after_berr  = bus_error;
    o_after_req   = dmem_req;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0; funct3_MEM = 3'b000;
    ALU_OUT_MEM = 32'h0; STORE_DATA_MEM = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_we", {31'h0, dmem_we}, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_be", {28'h0, dmem_be}, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_data", DATA_MEMORY_MEM, 32'h0);
    chk("rst_berr", {31'h0, bus_error}, 32'h0);
    chk("rst_stall", {31'h0, mem_stall}, 32'h0);
    reset = 1'b1;

    // LW 0x10, ack on first WAIT cycle
    run(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF);
    chk("lw_stall_idle", {31'h0, o_stall_idle}, 32'h1);
    chk("lw_fault", {31'h0, o_fault}, 32'h0);
    chk("lw_req", {31'h0, o_req}, 32'h1);
    chk("lw_we", {31'h0, o_we}, 32'h0);
    chk("lw_addr", o_addr, 32'h0000_0010);
    chk("lw_be", {28'h0, o_be}, 32'hF);
    chk("lw_wdata", o_wdata, 32'h0);
    chk("lw_waits", o_waits, 32'd1);
    chk("lw_done_stall", {31'h0, o_done_stall}, 32'h0);
    chk("lw_done_req", {31'h0, o_done_req}, 32'h0);
    chk("lw_data", o_data, 32'hDEAD_BEEF);
    chk("lw_berr", {31'h0, o_berr}, 32'h0);
    chk("lw_after_stall", {31'h0, o_after_stall}, 32'h0);
    chk("lw_after_req", {31'h0, o_after_req}, 32'h0);

    // LB / LBU lane 3, LHU upper half
    run(1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'h0, 0, 32'h8000_0000);
    chk("lb_be", {28'h0, o_be}, 32'h8);
    chk("lb_addr", o_addr, 32'h0000_0010);
    chk("lb_data", o_data, 32'hFFFF_FF80);
    run(1'b1, 1'b0, 3'b100, 32'h0000_0013, 32'h0, 0, 32'h8000_0000);
    chk("lbu_data", o_data, 32'h0000_0080);
    run(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0, 0, 32'h1234_0000);
    chk("lhu_be", {28'h0, o_be}, 32'hC);
    chk("lhu_data", o_data, 32'h0000_1234);
    run(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 1, 32'h8001_0000);
    chk("lh_waits", o_waits, 32'd2);
    chk("lh_data", o_data, 32'hFFFF_8001);

    // SB 0x21: data result must remain from the LH
    run(1'b0, 1'b1, 3'b000, 32'h0000_0021, 32'h0000_00A5, 0, 32'h5555_5555);
    chk("sb_req", {31'h0, o_req}, 32'h1);
    chk("sb_we", {31'h0, o_we}, 32'h1);
    chk("sb_be", {28'h0, o_be}, 32'h2);
    chk("sb_wdata", o_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", o_addr, 32'h0000_0020);
    chk("sb_data", o_data, 32'hFFFF_8001);
    run(1'b0, 1'b1, 3'b001, 32'h0000_0106, 32'h1234_BEEF, 0, 32'h0);
    chk("sh_be", {28'h0, o_be}, 32'hC);
    chk("sh_wdata", o_wdata, 32'hBEEF_BEEF);

    // Faults: no stall, no request
    run(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 0, 32'h0);
    chk("lw_mis_fault", {31'h0, o_fault}, 32'h1);
    chk("lw_mis_stall", {31'h0, o_stall_idle}, 32'h0);
    chk("lw_mis_req", {31'h0, o_req}, 32'h0);
    run(1'b0, 1'b1, 3'b001, 32'h0000_0005, 32'h0, 0, 32'h0);
    chk("sh_mis_fault", {31'h0, o_fault}, 32'h1);
    chk("sh_mis_stall", {31'h0, o_stall_idle}, 32'h0);
    chk("sh_mis_req", {31'h0, o_req}, 32'h0);
    run(1'b1, 1'b0, 3'b011, 32'h0000_0008, 32'h0, 0, 32'h0);
    chk("ill_fault", {31'h0, o_fault}, 32'h1);
    chk("ill_req", {31'h0, o_req}, 32'h0);
    run(1'b1, 1'b1, 3'b010, 32'h0000_0008, 32'h0, 0, 32'h0);
    chk("rw_fault", {31'h0, o_fault}, 32'h1);
    chk("rw_stall", {31'h0, o_stall_idle}, 32'h0);
    run(1'b0, 1'b1, 3'b100, 32'h0000_0008, 32'h0, 0, 32'h0);
    chk("st_ill_fault", {31'h0, o_fault}, 32'h1);

    // Timeout with no ack, then ack exactly on the abort cycle
    run(1'b1, 1'b0, 3'b010, 32'h0000_0030, 32'h0, -1, 32'h0);
    chk("to_waits", o_waits, 32'd4);
    chk("to_req", {31'h0, o_done_req}, 32'h0);
    chk("to_berr", {31'h0, o_berr}, 32'h1);
    chk("to_data", o_data, 32'h0);
    chk("to_berr_pulse", {31'h0, o_after_berr}, 32'h0);
    chk("to_after_stall", {31'h0, o_after_stall}, 32'h0);
    run(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 3, 32'hCAFE_F00D);
    chk("late_waits", o_waits, 32'd4);
    chk("late_berr", {31'h0, o_berr}, 32'h0);
    chk("late_data", o_data, 32'hCAFE_F00D);

    // Reset mid-WAIT, ack after release must be ignored
    @(negedge clk);
    MemRead_MEM = 1'b1; funct3_MEM = 3'b010; ALU_OUT_MEM = 32'h0000_0050;
    @(negedge clk);
    chk("mid_req_before", {31'h0, dmem_req}, 32'h1);
    reset = 1'b0; MemRead_MEM = 1'b0;
    #1;
    chk("mid_req", {31'h0, dmem_req}, 32'h0);
    chk("mid_addr", dmem_addr, 32'h0);
    chk("mid_be", {28'h0, dmem_be}, 32'h0);
    chk("mid_data", DATA_MEMORY_MEM, 32'h0);
    chk("mid_stall", {31'h0, mem_stall}, 32'h0);
    @(negedge clk);
    reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("mid_late_data", DATA_MEMORY_MEM, 32'h0);
    chk("mid_late_req", {31'h0, dmem_req}, 32'h0);
    chk("mid_late_stall", {31'h0, mem_stall}, 32'h0);
    run(1'b1, 1'b0, 3'b010, 32'h0000_0060, 32'h0, 0, 32'h0BAD_F00D);
    chk("post_rst_data", o_data, 32'h0BAD_F00D);
    chk("post_rst_waits", o_waits, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit between the EX/MEM pipeline register and mem_wb_pipe.
- Turns the ALU address, store data and funct3 into a req/ack transaction on the data-memory bus, and sign/zero-extends load data into DATA_MEMORY_MEM.
- Drives mem_stall, which holds the write enables of the upstream pipes and mem_wb_pipe until the access completes.

Parameters:
TIMEOUT, 16, max WAIT cycles without dmem_ack before the access is aborted (range 2..255).

Ports:
clk  input  1  clock; all state on posedge.
reset  input  1  asynchronous, active-low reset.
MemRead_MEM  input  1  load in MEM stage.
MemWrite_MEM  input  1  store in MEM stage.
funct3_MEM  input  3  access size/sign (RV32I encoding).
ALU_OUT_MEM  input  32  effective byte address.
STORE_DATA_MEM  input  32  rs2 value for stores.
dmem_req  output  1  bus request (registered).
dmem_we  output  1  1 = write (registered).
dmem_addr  output  32  word address, {ALU_OUT_MEM[31:2],2'b00} (registered).
dmem_be  output  4  byte enables (registered).
dmem_wdata  output  32  lane-replicated store data (registered).
dmem_rdata  input  32  read data, valid with dmem_ack.
dmem_ack  input  1  one-cycle completion strobe.
DATA_MEMORY_MEM  output  32  extended load result (registered) -> mem_wb_pipe.
mem_stall  output  1  combinational; 1 = MEM stage not complete.
access_fault  output  1  combinational; misaligned address, illegal funct3, or Read&Write both set.
bus_error  output  1  one-cycle pulse on timeout (registered).

Behaviour:
- Reset (reset=0, async): state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, DATA_MEMORY_MEM=0, bus_error=0, timeout counter=0. An in-flight access is abandoned and no later ack is honoured.
- access = MemRead_MEM | MemWrite_MEM.
- Legal funct3 values:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
  - anything else is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- fault = access & (illegal | misaligned | (MemRead_MEM & MemWrite_MEM)).
- FSM states are IDLE, WAIT, DONE.
  - IDLE:
    - access & ~fault: mem_stall=1 this cycle. Next edge loads dmem_req=1, dmem_we=MemWrite_MEM, addr/be/wdata, counter=0, then goes to WAIT.
    - fault: access_fault=1, mem_stall=0, no bus activity, state stays IDLE.
    - Otherwise idle, no stall.
  - WAIT:
    - mem_stall=1. dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are held stable.
    - On dmem_ack: dmem_req=0. For loads, DATA_MEMORY_MEM is updated from the extended dmem_rdata; stores leave it unchanged. Go to DONE.
    - Otherwise counter increments. If counter==TIMEOUT-1 with no ack: dmem_req=0, bus_error=1 for one cycle, DATA_MEMORY_MEM=0, go to DONE.
  - DONE: mem_stall=0 for exactly one cycle, so the pipeline advances and mem_wb_pipe captures the result. Always returns to IDLE. No reissue, even though the same instruction is still presented.
- dmem_ack in IDLE or DONE is ignored. An ack in the cycle the TIMEOUT abort fires wins: normal completion, no bus_error.
- Load extension (byte lane = addr[1:0], half lane = addr[1]):
  - LB / LBU: sign- / zero-extend the selected byte.
  - LH / LHU: sign- / zero-extend the selected halfword.
  - LW: whole word.
- Store formatting:
  - SB: be=4'b0001<<addr[1:0], wdata={4{byte}}.
  - SH: be=addr[1]?1100:0011, wdata={2{half}}.
  - SW: be=1111, wdata=data.
  - For loads, be follows the same size rule and wdata=0.
- Load-to-result latency is ack cycle + 1. Minimum MEM residency is 3 cycles (IDLE, WAIT with immediate ack, DONE).
- access_fault depends only on the IDLE-cycle inputs and is never asserted in WAIT or DONE.

Test Plan:
- LW addr=0x0000_0010, ack on 1st WAIT cycle, rdata=0xDEAD_BEEF -> be=1111, addr=0x10. DATA_MEMORY_MEM=0xDEADBEEF. mem_stall high 2 cycles, low in DONE.
- LB addr=0x13, rdata=0x8000_0000 -> DATA=0xFFFF_FF80. Same access as LBU -> 0x0000_0080. LHU addr=0x2, rdata=0x1234_0000 -> 0x0000_1234.
- SB addr=0x21, data=0x0000_00A5 -> dmem_we=1, be=0010, wdata=0xA5A5_A5A5, addr=0x20. DATA_MEMORY_MEM unchanged.
- LW addr=0x6 and SH addr=0x5 -> access_fault=1, mem_stall=0, dmem_req never asserted. funct3=011 load -> same response.
- TIMEOUT=4, no ack -> dmem_req drops after 4 WAIT cycles, bus_error one-cycle pulse, DATA=0, DONE then IDLE. Repeat with ack on the 4th WAIT cycle -> normal completion, no bus_error.
- reset=0 asserted mid-WAIT, then ack arrives after release -> all outputs 0 immediately, state IDLE, late ack ignored, next LW completes normally.
